// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient}; holds EX stalled through stallreq until ready.
module ex_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     opdata1,
  input  logic [WIDTH-1:0]     opdata2,
  output logic [2*WIDTH-1:0]   result,
  output logic                 ready,
  output logic                 busy,
  output logic                 stallreq
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic [2*WIDTH:0]   part_rem;
  logic [WIDTH-1:0]   divisor;
  logic               neg_quot;
  logic               neg_rem;

  logic [WIDTH-1:0]   abs_op1;
  logic [WIDTH-1:0]   abs_op2;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial_diff;
  logic [2*WIDTH:0]   next_rem;
  logic [WIDTH-1:0]   quot_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Magnitudes of the operands; unsigned divides pass straight through.
  always_comb begin
    abs_op1 = (signed_div && opdata1[WIDTH-1]) ? (~opdata1 + 1'b1) : opdata1;
    abs_op2 = (signed_div && opdata2[WIDTH-1]) ? (~opdata2 + 1'b1) : opdata2;
  end

  // One restoring step: shift, trial-subtract on the upper bits, keep the difference if non-negative.
  always_comb begin
    shifted    = {part_rem[2*WIDTH-1:0], 1'b0};
    trial_diff = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
    next_rem   = shifted;
    if (!trial_diff[WIDTH]) begin
      next_rem[2*WIDTH:WIDTH] = trial_diff;
      next_rem[0]             = 1'b1;
    end
    quot_raw = next_rem[WIDTH-1:0];
    rem_raw  = next_rem[2*WIDTH-1:WIDTH];
    quot_fix = neg_quot ? (~quot_raw + 1'b1) : quot_raw;
    rem_fix  = neg_rem  ? (~rem_raw  + 1'b1) : rem_raw;
  end

  // Divider FSM: operand capture, iteration, result hand-off and flush/reset abort.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= IDLE;
      result   <= '0;
      ready    <= 1'b0;
      counter  <= '0;
      part_rem <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            part_rem <= {{(WIDTH+1){1'b0}}, abs_op1};
            divisor  <= abs_op2;
            neg_quot <= signed_div && (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem  <= signed_div && opdata1[WIDTH-1];
            counter  <= '0;
            state    <= (opdata2 == '0) ? DIVZERO : ON;
          end
        end
        DIVZERO: begin
          result <= '0;
          state  <= END;
        end
        ON: begin
          part_rem <= next_rem;
          if (counter == LAST_ITER) begin
            result  <= {rem_fix, quot_fix};
            counter <= '0;
            state   <= END;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        END: begin
          if (start) begin
            ready <= 1'b1;
          end else begin
            ready  <= 1'b0;
            result <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign stallreq = start & ~ready;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: table-driven and randomized checks of ex_div_unit against an arithmetic model.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        busy;
  logic        stallreq;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  ex_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .signed_div(signed_div),
    .opdata1(opdata1), .opdata2(opdata2), .result(result), .ready(ready),
    .busy(busy), .stallreq(stallreq)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic, truncating division, zero divisor gives zero
  function automatic logic [63:0] refDiv(logic [31:0] a, logic [31:0] b, logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one divide with start held until ready, then drops start and checks the return to IDLE
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input bit scramble, output logic [63:0] res,
                               output int lat, output bit stall_ok);
    int cnt;
    @(negedge clk);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    cnt        = 0;
    stall_ok   = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (scramble && cnt == 5) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = ~signed_div;
      end
      if (!ready && stallreq !== 1'b1) stall_ok = 1'b0;
    end while (!ready && cnt < 100);
    lat = cnt - 1;
    res = result;
    if (ready && stallreq !== 1'b0) stall_ok = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drop_start_end", {ready, busy, result}, 66'd0);
  endtask

  initial begin
    logic [63:0] res;
    int          lat;
    bit          stall_ok;
    bit          ready_seen;
    logic [31:0] a, b;
    logic        s;

    vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33};
    vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33};
    vecs[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33};
    vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33};
    vecs[4] = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          33};
    vecs[5] = '{32'd5,          32'd0,          1'b0, 32'd0,          32'd0,          2};
    vecs[6] = '{32'hFFFFFFF8,   32'd0,          1'b1, 32'd0,          32'd0,          2};
    vecs[7] = '{32'hFFFFFFFA,   32'hFFFFFFFD,   1'b1, 32'd2,          32'd0,          33};
    vecs[8] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   33};

    rst = 1'b1; flush = 1'b0; start = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {ready, busy, result}, 66'd0);
    checkOutput("reset_stallreq", {65'd0, stallreq}, 66'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, res, lat, stall_ok);
      checkOutput($sformatf("vec%0d_result", i), {2'b00, res}, {2'b00, vecs[i].r, vecs[i].q});
      checkOutput($sformatf("vec%0d_latency", i), 66'(lat), 66'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_stallreq", i), {65'd0, stall_ok}, 66'd1);
    end

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i % 8 == 7) b = 32'd0;
      s = 1'($urandom_range(0, 1));
      applyStimulus(a, b, s, 1'b0, res, lat, stall_ok);
      checkOutput($sformatf("rand%0d_result", i), {2'b00, res}, {2'b00, refDiv(a, b, s)});
      checkOutput($sformatf("rand%0d_latency", i), 66'(lat), 66'((b == 32'd0) ? 2 : 33));
    end

    applyStimulus(32'd100, 32'd7, 1'b0, 1'b1, res, lat, stall_ok);
    checkOutput("scramble_result", {2'b00, res}, {2'b00, 32'd2, 32'd14});

    // Flush during the tenth ON cycle
    @(negedge clk);
    opdata1 = 32'd1000; opdata2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    checkOutput("flush_idle", {ready, busy, result}, 66'd0);
    ready_seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready || busy) ready_seen = 1'b1;
    end
    checkOutput("flush_no_ready", {65'd0, ready_seen}, 66'd0);
    applyStimulus(32'd9, 32'd3, 1'b0, 1'b0, res, lat, stall_ok);
    checkOutput("after_flush_result", {2'b00, res}, {2'b00, 32'd0, 32'd3});
    checkOutput("after_flush_latency", 66'(lat), 66'd33);

    // Reset in the middle of a division
    @(negedge clk);
    opdata1 = 32'd12345; opdata2 = 32'd17; signed_div = 1'b0; start = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_div", {ready, busy, result}, 66'd0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32'd12345, 32'd17, 1'b0, 1'b0, res, lat, stall_ok);
    checkOutput("after_rst_result", {2'b00, res}, {2'b00, refDiv(32'd12345, 32'd17, 1'b0)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
